// File: rtl/wb_stage.sv
// Writeback stage of the RV32I core: selects ALU/load/PC+4/immediate results,
// extracts load data and drives the register-file write port.

package type_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] data_t;
  typedef logic [XLEN-1:0] addr_t;
endpackage

package wb_stage_pkg;
  typedef enum logic [1:0] {
    SEL_WB_ALU = 2'd0,
    SEL_WB_MEM = 2'd1,
    SEL_WB_PC4 = 2'd2,
    SEL_WB_IMM = 2'd3
  } sel_wb_t;
endpackage

module wb_stage
  import type_pkg::data_t;
  import type_pkg::addr_t;
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  addr_t       pc,
  input  data_t       alu_result,
  input  data_t       imm,
  input  sel_wb_t     select,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic [2:0]  load_funct3,
  input  logic        dmem_rvalid,
  input  data_t       dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output data_t       rf_wdata,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t     state, state_n;
  logic       we_n;
  logic [4:0] waddr_n;
  data_t      wdata_n;

  logic [4:0] ld_rd, ld_rd_n;
  logic       ld_rw, ld_rw_n;
  logic [2:0] ld_f3, ld_f3_n;
  logic [1:0] ld_off, ld_off_n;

  logic [XLEN-1:0] load_val;

  // Unknown funct3 encodings fall through to a full-word load.
  function automatic data_t extract(input data_t word, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    data_t       r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign load_val = extract(dmem_rdata, ld_f3, ld_off);
  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state == WAIT_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      ld_rd    <= '0;
      ld_rw    <= 1'b0;
      ld_f3    <= '0;
      ld_off   <= '0;
    end else begin
      state    <= state_n;
      rf_we    <= we_n;
      rf_waddr <= waddr_n;
      rf_wdata <= wdata_n;
      ld_rd    <= ld_rd_n;
      ld_rw    <= ld_rw_n;
      ld_f3    <= ld_f3_n;
      ld_off   <= ld_off_n;
    end
  end

  // Write address/data only move when a write is issued, so they hold otherwise.
  always_comb begin
    state_n  = state;
    we_n     = 1'b0;
    waddr_n  = rf_waddr;
    wdata_n  = rf_wdata;
    ld_rd_n  = ld_rd;
    ld_rw_n  = ld_rw;
    ld_f3_n  = ld_f3;
    ld_off_n = ld_off;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (select == SEL_WB_MEM) begin
              ld_rd_n  = rd_addr;
              ld_rw_n  = reg_write;
              ld_f3_n  = load_funct3;
              ld_off_n = alu_result[1:0];
              state_n  = WAIT_MEM;
            end else begin
              we_n = reg_write && (rd_addr != 5'd0);
              if (we_n) begin
                waddr_n = rd_addr;
                case (select)
                  SEL_WB_PC4: wdata_n = pc + 32'd4;
                  SEL_WB_IMM: wdata_n = imm;
                  default:    wdata_n = alu_result;
                endcase
              end
            end
          end
        end
        WAIT_MEM: begin
          if (dmem_rvalid) begin
            we_n    = ld_rw && (ld_rd != 5'd0);
            state_n = IDLE;
            if (we_n) begin
              waddr_n = ld_rd;
              wdata_n = load_val;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// compared against a behavioural model of the writeback rules.

module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] pc, alu_result, imm, dmem_rdata, rf_wdata;
  sel_wb_t     select;
  logic [4:0]  rd_addr, rf_waddr;
  logic        reg_write, dmem_rvalid, rf_we, busy;
  logic [2:0]  load_funct3;

  int compareCount = 0;
  int mismatchCount = 0;

  // Behavioural model state
  bit          mPending = 1'b0;
  logic [4:0]  mRd;
  bit          mRw;
  logic [2:0]  mF3;
  logic [1:0]  mOff;
  bit          mWe = 1'b0;
  logic [4:0]  mWaddr = 5'd0;
  logic [31:0] mWdata = 32'd0;
  bit          mReset = 1'b0;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .alu_result(alu_result), .imm(imm), .select(select),
    .rd_addr(rd_addr), .reg_write(reg_write), .load_funct3(load_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Load extraction from the ISA rules: shift the addressed lane down, then extend.
  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] shB, shH;
    shB = word >> (8 * int'(off));
    shH = word >> (off[1] ? 16 : 0);
    case (f3)
      3'd0:    return 32'($signed(shB[7:0]));
      3'd4:    return 32'(shB[7:0]);
      3'd1:    return 32'($signed(shH[15:0]));
      3'd5:    return 32'(shH[15:0]);
      default: return word;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict, clock, then compare.
  task automatic applyStimulus(input bit r, input bit f, input bit v, input sel_wb_t s,
                               input logic [31:0] pcI, input logic [31:0] aluI,
                               input logic [31:0] immI, input logic [4:0] rd,
                               input bit rw, input logic [2:0] f3, input bit rv,
                               input logic [31:0] rdata);
    @(negedge clk);
    rst = r; flush = f; in_valid = v; select = s; pc = pcI; alu_result = aluI;
    imm = immI; rd_addr = rd; reg_write = rw; load_funct3 = f3;
    dmem_rvalid = rv; dmem_rdata = rdata;
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(!mPending && !f));
    checkOutput("busy_pre", 32'(busy), 32'(mPending));
    mReset = r;
    mWe = 1'b0;
    if (r) begin
      mPending = 1'b0; mWaddr = 5'd0; mWdata = 32'd0;
    end else if (f) begin
      mPending = 1'b0;
    end else if (mPending) begin
      if (rv) begin
        mPending = 1'b0;
        mWe = mRw && (mRd != 5'd0);
        if (mWe) begin
          mWaddr = mRd;
          mWdata = refLoad(rdata, mF3, mOff);
        end
      end
    end else if (v) begin
      if (s == SEL_WB_MEM) begin
        mPending = 1'b1; mRd = rd; mRw = rw; mF3 = f3; mOff = aluI[1:0];
      end else begin
        mWe = rw && (rd != 5'd0);
        if (mWe) begin
          mWaddr = rd;
          mWdata = (s == SEL_WB_PC4) ? pcI + 32'd4 : (s == SEL_WB_IMM) ? immI : aluI;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rf_we", 32'(rf_we), 32'(mWe));
    checkOutput("busy", 32'(busy), 32'(mPending));
    if (mWe || mReset) begin
      checkOutput("rf_waddr", 32'(rf_waddr), 32'(mWaddr));
      checkOutput("rf_wdata", rf_wdata, mWdata);
    end
  endtask

  task automatic idleCycle(input bit rv);
    applyStimulus(0, 0, 0, SEL_WB_ALU, 0, 0, 0, 0, 0, 0, rv, 32'h80FF_7F01);
  endtask

  task automatic aluOp(input logic [4:0] rd, input logic [31:0] val);
    applyStimulus(0, 0, 1, SEL_WB_ALU, 0, val, 0, rd, 1, 0, 0, 0);
  endtask

  task automatic loadOp(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    applyStimulus(0, 0, 1, SEL_WB_MEM, 0, 32'h1000_0000 | 32'(off), 0, rd, 1, f3, 0, 0);
  endtask

  logic [2:0]  ldF3[5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ldOff[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [31:0] ldExp[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                            32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    rst = 1; flush = 0; in_valid = 0; select = SEL_WB_ALU; pc = 0; alu_result = 0;
    imm = 0; rd_addr = 0; reg_write = 0; load_funct3 = 0; dmem_rvalid = 0; dmem_rdata = 0;

    applyStimulus(1, 0, 0, SEL_WB_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, SEL_WB_ALU, 0, 32'hDEAD_BEEF, 0, 5'd3, 1, 0, 0, 0);
    checkOutput("reset_we", 32'(rf_we), 32'd0);
    checkOutput("reset_wdata", rf_wdata, 32'd0);

    // ALU, PC+4 wrap, immediate and x0 paths
    aluOp(5'd5, 32'h1234_5678);
    checkOutput("alu_we", 32'(rf_we), 32'd1);
    checkOutput("alu_waddr", 32'(rf_waddr), 32'd5);
    checkOutput("alu_wdata", rf_wdata, 32'h1234_5678);
    idleCycle(0);
    checkOutput("alu_pulse", 32'(rf_we), 32'd0);
    applyStimulus(0, 0, 1, SEL_WB_PC4, 32'hFFFF_FFFC, 0, 0, 5'd6, 1, 0, 0, 0);
    checkOutput("pc4_wrap", rf_wdata, 32'd0);
    applyStimulus(0, 0, 1, SEL_WB_IMM, 0, 0, 32'hABCD_E000, 5'd7, 1, 0, 0, 0);
    checkOutput("imm", rf_wdata, 32'hABCD_E000);
    aluOp(5'd0, 32'h5555_AAAA);
    checkOutput("x0_we", 32'(rf_we), 32'd0);

    // Load extraction with a three-cycle memory wait
    for (int i = 0; i < 5; i++) begin
      loadOp(5'(10 + i), ldF3[i], ldOff[i]);
      for (int w = 0; w < 3; w++) idleCycle(0);
      checkOutput("wait_busy", 32'(busy), 32'd1);
      idleCycle(1);
      checkOutput("load_data", rf_wdata, ldExp[i]);
    end

    // Throughput: four ALU ops, a fast load, then an ALU op straight after rvalid
    for (int i = 1; i <= 4; i++) begin
      aluOp(5'(i), 32'(i * 16));
      checkOutput("b2b_we", 32'(rf_we), 32'd1);
    end
    loadOp(5'd20, 3'd2, 2'd0);
    idleCycle(1);
    checkOutput("fast_load_we", 32'(rf_we), 32'd1);
    aluOp(5'd21, 32'h0BAD_F00D);
    checkOutput("after_load_waddr", 32'(rf_waddr), 32'd21);

    // Flush and reset in the middle of a load
    loadOp(5'd22, 3'd2, 2'd0);
    idleCycle(0);
    applyStimulus(0, 1, 0, SEL_WB_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_idle", 32'(busy), 32'd0);
    idleCycle(0);
    idleCycle(1);
    checkOutput("flush_late_rv", 32'(rf_we), 32'd0);
    loadOp(5'd23, 3'd2, 2'd0);
    applyStimulus(1, 0, 0, SEL_WB_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle(0);
    idleCycle(1);
    checkOutput("rst_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("rst_wdata", rf_wdata, 32'd0);

    // Priority rules
    loadOp(5'd24, 3'd2, 2'd0);
    applyStimulus(0, 1, 0, SEL_WB_ALU, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    checkOutput("flush_vs_rv", 32'(rf_we), 32'd0);
    applyStimulus(0, 1, 1, SEL_WB_ALU, 0, 32'h7777_7777, 0, 5'd9, 1, 0, 0, 0);
    checkOutput("flush_vs_valid", 32'(rf_we), 32'd0);
    idleCycle(1);
    checkOutput("idle_rv", 32'(rf_we), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                    ($urandom_range(1) == 1), sel_wb_t'($urandom_range(3)),
                    $urandom, $urandom, $urandom, 5'($urandom_range(31)),
                    ($urandom_range(3) != 0), 3'($urandom_range(7)),
                    ($urandom_range(2) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
